// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch stage with request/grant/response memory
// handshake, 2-entry output queue with EXTOP pre-decode, and redirect flush.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] INSTR,
  output logic [31:0] PC_OUT,
  output logic [2:0]  EXTOP
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  extop;
  } entry_t;

  logic [31:0] fpc_r;
  logic [1:0]  osd_r;
  logic [1:0]  drop_r;
  logic [1:0]  cnt_r;
  logic [31:0] aq_r [2];
  logic        aq_wp_r;
  logic        aq_rp_r;
  entry_t      q_r [2];

  logic        req_s;
  logic        grant_s;
  logic        rsp_s;
  logic        drop_hit_s;
  logic        push_s;
  logic        pop_s;
  logic [1:0]  osd_nxt_s;
  logic [1:0]  drop_nxt_s;
  logic [1:0]  cnt_nxt_s;
  entry_t      new_s;

  function automatic logic [2:0] decode_extop(input logic [6:0] opc);
    logic [2:0] ext;
    case (opc)
      7'b0010011, 7'b0000011, 7'b1100111: ext = 3'b000;
      7'b0110111, 7'b0010111:             ext = 3'b001;
      7'b0100011:                         ext = 3'b010;
      7'b1100011:                         ext = 3'b011;
      7'b1101111:                         ext = 3'b100;
      default:                            ext = 3'b000;
    endcase
    return ext;
  endfunction

  // Handshake qualification and next values of the occupancy counters
  always_comb begin
    req_s      = 1'b0;
    osd_nxt_s  = osd_r;
    drop_nxt_s = drop_r;
    cnt_nxt_s  = cnt_r;
    if (RST_N && !REDIRECT && (({1'b0, cnt_r} + {1'b0, osd_r}) < 3'd2)) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
    grant_s      = req_s & IMEM_GNT;
    // A response with nothing outstanding is a leftover from before reset
    rsp_s        = IMEM_RVALID & (osd_r != 2'd0);
    drop_hit_s   = rsp_s & (drop_r != 2'd0);
    push_s       = rsp_s & ~drop_hit_s & ~REDIRECT;
    pop_s        = (cnt_r != 2'd0) & OUT_READY & ~REDIRECT;
    new_s.instr  = IMEM_RDATA;
    new_s.pc     = aq_r[aq_rp_r];
    new_s.extop  = decode_extop(IMEM_RDATA[6:0]);
    case ({grant_s, rsp_s})
      2'b10:   osd_nxt_s = osd_r + 2'd1;
      2'b01:   osd_nxt_s = osd_r - 2'd1;
      default: osd_nxt_s = osd_r;
    endcase
    // Everything still outstanding after a redirect belongs to the old stream
    if (REDIRECT) begin
      drop_nxt_s = osd_nxt_s;
    end else if (drop_hit_s) begin
      drop_nxt_s = drop_r - 2'd1;
    end else begin
      drop_nxt_s = drop_r;
    end
    if (REDIRECT) begin
      cnt_nxt_s = 2'd0;
    end else begin
      cnt_nxt_s = cnt_r + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

  // Fetch PC, counters and issue-address FIFO
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      fpc_r   <= RESET_PC & 32'hFFFF_FFFC;
      osd_r   <= 2'd0;
      drop_r  <= 2'd0;
      cnt_r   <= 2'd0;
      aq_r[0] <= 32'd0;
      aq_r[1] <= 32'd0;
      aq_wp_r <= 1'b0;
      aq_rp_r <= 1'b0;
    end else begin
      if (REDIRECT) begin
        fpc_r <= REDIRECT_PC & 32'hFFFF_FFFC;
      end else if (grant_s) begin
        fpc_r <= fpc_r + 32'd4;
      end
      if (grant_s) begin
        aq_r[aq_wp_r] <= fpc_r;
        aq_wp_r       <= ~aq_wp_r;
      end
      if (rsp_s) begin
        aq_rp_r <= ~aq_rp_r;
      end
      osd_r  <= osd_nxt_s;
      drop_r <= drop_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  // Output queue storage; entry 0 is always the presented head
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      q_r[0] <= '0;
      q_r[1] <= '0;
    end else if (push_s && pop_s) begin
      if (cnt_r == 2'd2) begin
        q_r[0] <= q_r[1];
        q_r[1] <= new_s;
      end else begin
        q_r[0] <= new_s;
      end
    end else if (pop_s) begin
      q_r[0] <= q_r[1];
    end else if (push_s) begin
      if (cnt_r == 2'd0) begin
        q_r[0] <= new_s;
      end else begin
        q_r[1] <= new_s;
      end
    end
  end

  assign IMEM_REQ  = req_s;
  assign IMEM_ADDR = fpc_r;
  assign OUT_VALID = (cnt_r != 2'd0);
  assign INSTR     = q_r[0].instr;
  assign PC_OUT    = q_r[0].pc;
  assign EXTOP     = q_r[0].extop;

endmodule
